mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//   Arbitrates and sequences the single byte-wide memory port between instruction fetch (IF)
//   and the load/store unit (LSU).
//   - Breaks word fetches and LB/LH/LW/LBU/LHU/SB/SH/SW into little-endian byte beats.
//   - Reassembles and sign/zero-extends load data.
//   - Sits between the IF/LSU stages and the external RAM port.
// PARAMETERS
//   ADDR_W   32   memory address width; beat address wraps mod 2^ADDR_W
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous, active-high reset
//   if_req      in   1       IF requests a 4-byte read
//   if_addr     in   ADDR_W  IF byte address
//   if_done     out  1       one-cycle pulse: if_data valid
//   if_data     out  32      fetched instruction word
//   lsu_req     in   1       LSU requests an access
//   lsu_we      in   1       1 = store, 0 = load
//   lsu_size    in   2       `MEM_SIZE_B(00) / `MEM_SIZE_H(01) / `MEM_SIZE_W(10); 11 is treated as W
//   lsu_signed  in   1       loads only: 1 = sign-extend (LB/LH), 0 = zero-extend (LBU/LHU)
//   lsu_addr    in   ADDR_W  LSU byte address
//   lsu_wdata   in   32      store data; low bytes used per lsu_size
//   lsu_done    out  1       one-cycle pulse: access complete, lsu_rdata valid for loads
//   lsu_rdata   out  32      extended load data
//   mem_a       out  ADDR_W  RAM byte address
//   mem_dout    out  8       RAM write byte
//   mem_wr      out  1       RAM write strobe
//   mem_din     in   8       RAM read byte; valid one cycle after mem_a is presented
//   busy        out  1       high while in RD or WR
// BEHAVIOUR
//   - Reset: state IDLE, cnt=0, priority pointer=LSU. Every output is 0.
//   - Reset mid-transaction aborts immediately: mem_wr drops at once, no done pulse.
//   - FSM states: IDLE, RD, WR.
//     - IDLE samples requests. A grant latches addr/size/signed/wdata and the requester ID, sets cnt=0,
//       and moves to RD (IF, or LSU load) or WR (LSU store).
//     - N = number of bytes: 1, 2 or 4; IF always uses N=4.
//   - RD: beat k (k=0..N-1) drives mem_a=base+k and mem_wr=0.
//     - mem_din captured in the following cycle is byte k, placed at bits [8k+7:8k].
//     - Leave RD after byte N-1 is captured.
//     - done and data are registered: done pulses N+2 cycles after the grant cycle (word: 6).
//   - WR: beat k drives mem_a=base+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
//     - lsu_done pulses N+1 cycles after the grant cycle, in the cycle after the last write beat.
//   - The done cycle is spent in IDLE with arbitration masked. The next grant is evaluated the
//     following cycle, so a requester must drop req in its done cycle or it restarts.
//   - Outside beats: mem_a=0, mem_dout=0, mem_wr=0. Done pulses last exactly one cycle.
//   - rdata/if_data hold their value until the next completion of the same requester.
//   - Load extension: B gives {24{s&b[7]}, b}; H gives {16{s&h[15]}, h}; W passes through.
//   - Both requesters high in IDLE: winner per CONFIGURATION.
//   - Requester inputs are ignored while busy. Dropping req mid-transaction is a protocol
//     violation; the transaction still completes and done still pulses.
//   - Unaligned addresses are legal: each beat is a byte, with no alignment check.
//   - base+k wraps from 2^ADDR_W-1 to 0.
// CONFIGURATION
//   MEM_CTRL_RR_EN
//   - Defined: round-robin. The pointer flips to the other requester after each completed
//     transaction, and the pointed requester wins a tie.
//   - Undefined: fixed priority, LSU always wins a tie. IF starvation under continuous LSU
//     traffic is accepted.
// STRUCTURE
//   - Shared defines header holds: `word_t, `addr_t, the `MEM_SIZE_B/H/W encodings, and the
//     IDLE/RD/WR state codes. These are shared with the LSU.
//   - One combinational sub-module, mem_ld_extend (in: word, size, signed; out: extended word),
//     reused by the LSU forward path.
//   - FSM, beat counter, arbitration and assembly registers live in mem_ctrl.
// TESTING
//   1. IF word read at 0x1000, RAM bytes 13 05 00 00 -> if_done pulses in cycle 6 after the
//      grant, if_data=0x00000513, mem_wr stays 0.
//   2. LSU LB at 0x20 holding 0x80, signed -> lsu_rdata=0xFFFFFF80; LBU of the same byte ->
//      0x00000080; LH at 0x20 with bytes 80 7F, signed -> lsu_rdata=0x00007F80.
//   3. LSU SW of 0xDEADBEEF at 0x40 -> mem_wr=1 for 4 cycles with mem_a=0x40..0x43 and
//      mem_dout EF,BE,AD,DE; lsu_done pulses in cycle 5.
//   4. if_req and lsu_req asserted together, held for 3 transactions each -> without
//      MEM_CTRL_RR_EN all LSU grants come first; with it, grants alternate LSU,IF,LSU.
//   5. rst asserted during beat 2 of an SW -> mem_wr=0 immediately, no lsu_done, byte at +2
//      not written, and the next request after reset is served normally.
//   6. LH at 0xFFFFFFFF -> beats at 0xFFFFFFFF then 0x00000000; req held through the done
//      cycle -> a second transaction starts exactly 1 cycle after done.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-wide memory controller and the LSU.
// Holds word/address types, access-size encodings, FSM state codes
// and the beat-count helper.
package mem_ctrl_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    // Bytes moved for an access size; 2'b11 behaves as a word.
    function automatic logic [2:0] size_beats(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_beats = 3'd1;
            MEM_SIZE_H: size_beats = 3'd2;
            default:    size_beats = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle between IF/LSU requesters, the RAM port and mem_ctrl.
// slave: mem_ctrl side; master: requester/RAM side.
// Signals: if_req/if_addr/if_done/if_data, lsu_req/we/size/signed/
// addr/wdata/done/rdata, mem_a/mem_dout/mem_wr/mem_din, busy.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    import mem_ctrl_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    word_t             if_data;

    logic              lsu_req;
    logic              lsu_we;
    logic [1:0]        lsu_size;
    logic              lsu_signed;
    logic [ADDR_W-1:0] lsu_addr;
    word_t             lsu_wdata;
    logic              lsu_done;
    word_t             lsu_rdata;

    logic [ADDR_W-1:0] mem_a;
    logic [7:0]        mem_dout;
    logic              mem_wr;
    logic [7:0]        mem_din;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  lsu_req, lsu_we, lsu_size, lsu_signed,
        input  lsu_addr, lsu_wdata,
        input  mem_din,
        output if_done, if_data, lsu_done, lsu_rdata,
        output mem_a, mem_dout, mem_wr, busy
    );

    modport master (
        output if_req, if_addr,
        output lsu_req, lsu_we, lsu_size, lsu_signed,
        output lsu_addr, lsu_wdata,
        output mem_din,
        input  if_done, if_data, lsu_done, lsu_rdata,
        input  mem_a, mem_dout, mem_wr, busy
    );

endinterface

// File: rtl/mem_ld_extend.sv
// Load-data sign/zero extension, shared with the LSU forward path.
// Ports: i_word (assembled bytes), i_size, i_signed -> o_word.
module mem_ld_extend
    import mem_ctrl_pkg::*;
(
    input  word_t      i_word,
    input  logic [1:0] i_size,
    input  logic       i_signed,
    output word_t      o_word
);

    always_comb begin
        o_word = i_word;
        case (i_size)
            MEM_SIZE_B:
                o_word = {{24{i_signed & i_word[7]}}, i_word[7:0]};
            MEM_SIZE_H:
                o_word = {{16{i_signed & i_word[15]}}, i_word[15:0]};
            default:
                o_word = i_word;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates one byte-wide RAM port between IF and LSU, splitting
// accesses into little-endian byte beats and reassembling loads.
// Ports: clk, rst (async, active-high), bus (mem_ctrl_if.slave).
// Option MEM_CTRL_RR_EN: round-robin tie-break instead of LSU-first.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    state_e            r_state;
    logic [2:0]        r_cnt;
    logic              r_is_if;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_sgn;
    word_t             r_wdata;
    word_t             r_buf;

    logic              r_if_done;
    word_t             r_if_data;
    logic              r_lsu_done;
    word_t             r_lsu_rdata;
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_dout;
    logic              r_mem_wr;

`ifdef MEM_CTRL_RR_EN
    logic              r_ptr;
`endif

    logic              w_masked;
    logic              w_grant;
    logic              w_pick_if;
    logic [2:0]        w_n;
    logic [2:0]        w_cnt1;
    logic [ADDR_W-1:0] w_next_a;
    logic [5:0]        w_shift;
    word_t             w_buf_nxt;
    word_t             w_ext;
    logic [7:0]        w_byte_nxt;

    // The done cycle is spent in IDLE without arbitrating.
    assign w_masked = r_if_done | r_lsu_done;
    assign w_grant  = (r_state == ST_IDLE) & ~w_masked
                    & (bus.if_req | bus.lsu_req);

`ifdef MEM_CTRL_RR_EN
    // r_ptr = 1 means IF owns the tie.
    assign w_pick_if = bus.if_req & (~bus.lsu_req | r_ptr);
`else
    assign w_pick_if = bus.if_req & ~bus.lsu_req;
`endif

    assign w_n      = size_beats(r_size);
    assign w_cnt1   = r_cnt + 3'd1;
    assign w_next_a = r_addr + ADDR_W'(w_cnt1);

    // In RD, mem_din lags mem_a by one cycle: it holds byte cnt-1.
    assign w_shift   = {r_cnt - 3'd1, 3'b000};
    assign w_buf_nxt = r_buf | (word_t'(bus.mem_din) << w_shift);

    assign w_byte_nxt = r_wdata[{w_cnt1[1:0], 3'b000} +: 8];

    mem_ld_extend u_ext (
        .i_word   (w_buf_nxt),
        .i_size   (r_size),
        .i_signed (r_sgn),
        .o_word   (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_is_if     <= 1'b0;
            r_addr      <= '0;
            r_size      <= '0;
            r_sgn       <= 1'b0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_if_done   <= 1'b0;
            r_if_data   <= '0;
            r_lsu_done  <= 1'b0;
            r_lsu_rdata <= '0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_mem_wr    <= 1'b0;
`ifdef MEM_CTRL_RR_EN
            r_ptr       <= 1'b0;
`endif
        end else begin
            r_if_done  <= 1'b0;
            r_lsu_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_is_if <= w_pick_if;
                        r_cnt   <= '0;
                        r_buf   <= '0;
                        if (w_pick_if) begin
                            r_addr  <= bus.if_addr;
                            r_size  <= MEM_SIZE_W;
                            r_sgn   <= 1'b0;
                            r_wdata <= '0;
                            r_mem_a <= bus.if_addr;
                            r_state <= ST_RD;
                        end else begin
                            r_addr  <= bus.lsu_addr;
                            r_size  <= bus.lsu_size;
                            r_sgn   <= bus.lsu_signed;
                            r_wdata <= bus.lsu_wdata;
                            r_mem_a <= bus.lsu_addr;
                            if (bus.lsu_we) begin
                                r_mem_wr   <= 1'b1;
                                r_mem_dout <= bus.lsu_wdata[7:0];
                                r_state    <= ST_WR;
                            end else begin
                                r_state <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    r_cnt <= w_cnt1;
                    if (r_cnt != 3'd0) r_buf <= w_buf_nxt;
                    r_mem_a <= (w_cnt1 < w_n) ? w_next_a : '0;
                    if (r_cnt == w_n) begin
                        r_state <= ST_IDLE;
`ifdef MEM_CTRL_RR_EN
                        r_ptr   <= ~r_ptr;
`endif
                        if (r_is_if) begin
                            r_if_done <= 1'b1;
                            r_if_data <= w_ext;
                        end else begin
                            r_lsu_done  <= 1'b1;
                            r_lsu_rdata <= w_ext;
                        end
                    end
                end
                ST_WR: begin
                    if (r_cnt == w_n - 3'd1) begin
                        r_mem_wr   <= 1'b0;
                        r_mem_a    <= '0;
                        r_mem_dout <= '0;
                        r_lsu_done <= 1'b1;
                        r_state    <= ST_IDLE;
`ifdef MEM_CTRL_RR_EN
                        r_ptr      <= ~r_ptr;
`endif
                    end else begin
                        r_cnt      <= w_cnt1;
                        r_mem_a    <= w_next_a;
                        r_mem_dout <= w_byte_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_done   = r_if_done;
    assign bus.if_data   = r_if_data;
    assign bus.lsu_done  = r_lsu_done;
    assign bus.lsu_rdata = r_lsu_rdata;
    assign bus.mem_a     = r_mem_a;
    assign bus.mem_dout  = r_mem_dout;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed cases plus random
// IF/LSU traffic checked against a byte-array memory model.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_ctrl_if bus ();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM: registered read, one-cycle latency; writes on mem_wr.
    logic [7:0] ram   [logic [31:0]];
    logic [7:0] model [logic [31:0]];

    always @(posedge clk) begin
        bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] last_if  = 32'h0;
    logic [31:0] last_lsu = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mb(input logic [31:0] a);
        return model.exists(a) ? model[a] : 8'h00;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]   = b;
        model[a] = b;
    endtask

    function automatic int beats(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    // Little-endian value of n bytes, reinterpreted as two's complement
    // when signed and narrower than a word.
    function automatic logic [31:0] ref_load(input logic [31:0] a,
                                             input int n, input bit sgn);
        longint v;
        v = 0;
        for (int k = 0; k < n; k++)
            v += longint'(mb(a + 32'(k))) << (8 * k);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    // Called at a negedge with the controller idle and not masked.
    task automatic run_txn(input bit is_if, input bit we,
                           input logic [1:0] size, input bit sgn,
                           input logic [31:0] addr,
                           input logic [31:0] wdata);
        int n;
        int dc;
        logic [31:0] exp;
        logic [31:0] bexp;
        string dtag;
        bit rd;
        rd   = is_if || !we;
        n    = is_if ? 4 : beats(size);
        dc   = rd ? n + 2 : n + 1;
        exp  = rd ? ref_load(addr, n, is_if ? 1'b0 : sgn) : 32'h0;
        dtag = is_if ? "if_done" : "lsu_done";
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.lsu_req    = 1'b1;
            bus.lsu_we     = we;
            bus.lsu_size   = size;
            bus.lsu_signed = sgn;
            bus.lsu_addr   = addr;
            bus.lsu_wdata  = wdata;
        end
        @(posedge clk);
        for (int c = 1; c <= dc; c++) begin
            @(negedge clk);
            chk("busy", 32'(bus.busy), 32'(c < dc));
            chk(dtag, 32'(is_if ? bus.if_done : bus.lsu_done),
                32'(c == dc));
            chk("other_done", 32'(is_if ? bus.lsu_done : bus.if_done),
                32'h0);
            if (!rd && c <= n) begin
                bexp = (wdata >> (8 * (c - 1))) & 32'hFF;
                chk("wr_strobe", 32'(bus.mem_wr), 32'h1);
                chk("wr_addr", bus.mem_a, addr + 32'(c - 1));
                chk("wr_byte", 32'(bus.mem_dout), bexp);
            end else begin
                chk("no_wr", 32'(bus.mem_wr), 32'h0);
            end
            if (c == dc) begin
                if (is_if) begin
                    chk("if_data", bus.if_data, exp);
                    last_if = exp;
                    chk("lsu_rdata_hold", bus.lsu_rdata, last_lsu);
                end else begin
                    if (!we) begin
                        chk("lsu_rdata", bus.lsu_rdata, exp);
                        last_lsu = exp;
                    end
                    chk("if_data_hold", bus.if_data, last_if);
                end
                bus.if_req  = 1'b0;
                bus.lsu_req = 1'b0;
            end
        end
        if (!rd)
            for (int k = 0; k < n; k++)
                model[addr + 32'(k)] = wdata[8 * k +: 8];
        @(posedge clk);
        @(negedge clk);
    endtask

    string seq;
    string seq_exp;
    int ni;
    int nl;

    initial begin
        rst            = 1'b1;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.lsu_req    = 1'b0;
        bus.lsu_we     = 1'b0;
        bus.lsu_size   = 2'd0;
        bus.lsu_signed = 1'b0;
        bus.lsu_addr   = '0;
        bus.lsu_wdata  = '0;

        preload(32'h1000, 8'h13);
        preload(32'h1001, 8'h05);
        preload(32'h1002, 8'h00);
        preload(32'h1003, 8'h00);
        preload(32'h20, 8'h80);
        preload(32'h21, 8'h7F);
        preload(32'hFFFF_FFFF, 8'h34);
        preload(32'h0, 8'h92);
        preload(32'h80, 8'hAA);
        preload(32'h81, 8'hBB);
        preload(32'h82, 8'hCC);
        preload(32'h83, 8'hDD);

        repeat (3) @(negedge clk);
        chk("rst_if_done", 32'(bus.if_done), 32'h0);
        chk("rst_lsu_done", 32'(bus.lsu_done), 32'h0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_if_data", bus.if_data, 32'h0);
        chk("rst_lsu_rdata", bus.lsu_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Word fetch
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
        chk("fetch_word", last_if, 32'h0000_0513);

        // Byte/half loads with extension
        run_txn(1'b0, 1'b0, 2'd0, 1'b1, 32'h20, 32'h0);
        chk("lb", last_lsu, 32'hFFFF_FF80);
        run_txn(1'b0, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
        chk("lbu", last_lsu, 32'h0000_0080);
        run_txn(1'b0, 1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
        chk("lh", last_lsu, 32'h0000_7F80);

        // Word store, then read back
        run_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF);
        run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        chk("sw_readback", last_lsu, 32'hDEAD_BEEF);

        // Wrapping LH with req held through done: back-to-back restart
        bus.lsu_req    = 1'b1;
        bus.lsu_we     = 1'b0;
        bus.lsu_size   = 2'd1;
        bus.lsu_signed = 1'b1;
        bus.lsu_addr   = 32'hFFFF_FFFF;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("wrap_done", 32'(bus.lsu_done), 32'(c == 4 || c == 9));
            if (c == 4 || c == 9)
                chk("wrap_lh", bus.lsu_rdata, 32'hFFFF_9234);
            if (c == 5) chk("restart_idle", 32'(bus.busy), 32'h0);
            if (c == 6) chk("restart_busy", 32'(bus.busy), 32'h1);
        end
        bus.lsu_req = 1'b0;
        last_lsu = 32'hFFFF_9234;
        @(posedge clk);
        @(negedge clk);

        // Reset during beat 2 of a word store
        bus.lsu_req   = 1'b1;
        bus.lsu_we    = 1'b1;
        bus.lsu_size  = 2'd2;
        bus.lsu_addr  = 32'h80;
        bus.lsu_wdata = 32'h1122_3344;
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("beat2_addr", bus.mem_a, 32'h82);
        chk("beat2_wr", 32'(bus.mem_wr), 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_wr", 32'(bus.mem_wr), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        bus.lsu_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.lsu_done), 32'h0);
        end
        rst = 1'b0;
        last_if  = 32'h0;
        last_lsu = 32'h0;
        model[32'h80] = 8'h44;
        model[32'h81] = 8'h33;
        @(negedge clk);
        run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        chk("abort_readback", last_lsu, 32'hDDCC_3344);

        // Simultaneous requests, each held for three completions
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_if  = 32'h0;
        last_lsu = 32'h0;
        @(negedge clk);
        seq = "";
        ni  = 0;
        nl  = 0;
        bus.if_addr    = 32'h1000;
        bus.lsu_we     = 1'b0;
        bus.lsu_size   = 2'd2;
        bus.lsu_signed = 1'b0;
        bus.lsu_addr   = 32'h20;
        bus.if_req     = 1'b1;
        bus.lsu_req    = 1'b1;
        for (int c = 0; c < 200 && (ni < 3 || nl < 3); c++) begin
            @(negedge clk);
            if (bus.lsu_done) begin
                seq = {seq, "L"};
                nl++;
                if (nl == 3) bus.lsu_req = 1'b0;
            end
            if (bus.if_done) begin
                seq = {seq, "I"};
                ni++;
                if (ni == 3) bus.if_req = 1'b0;
            end
        end
        bus.if_req  = 1'b0;
        bus.lsu_req = 1'b0;
`ifdef MEM_CTRL_RR_EN
        seq_exp = "LILILI";
`else
        seq_exp = "LLLIII";
`endif
        n_checks++;
        assert (seq == seq_exp) else begin
            n_err++;
            $error("FAIL arb_order: observed %s expected %s",
                   seq, seq_exp);
        end
        last_if  = ref_load(32'h1000, 4, 1'b0);
        last_lsu = ref_load(32'h20, 4, 1'b0);
        chk("arb_if_data", bus.if_data, last_if);
        chk("arb_lsu_rdata", bus.lsu_rdata, last_lsu);
        @(posedge clk);
        @(negedge clk);

        // Random traffic, including unaligned and wrapping addresses
        for (int i = 0; i < 32; i++) begin
            preload(32'h200 + 32'(i), 8'($urandom));
            preload(32'hFFFF_FFF0 + 32'(i), 8'($urandom));
        end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 1) == 0)
              ? 32'h200 + 32'($urandom_range(0, 27))
              : 32'hFFFF_FFFA + 32'($urandom_range(0, 9));
            run_txn($urandom_range(0, 3) == 0,
                    1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
